// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared op/exception encodings and constants for the memory stage load/store unit
package mem_stage_lsu_pkg;
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8,
    OP_LL   = 4'd9,
    OP_SC   = 4'd10
  } mem_op_e;
  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_LMIS = 2'd1,
    EXC_SMIS = 2'd2,
    EXC_BUS  = 2'd3
  } exc_e;
  localparam int          NOP_REG   = 0;
  localparam logic        WRITE_EN  = 1'b1;
  localparam logic        WRITE_DIS = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/mem_stage_lsu_align.sv
// mem_stage_lsu_align: lane select, store replication, load extraction and misalignment (LL/SC decoded when MEM_LSU_LLSC_EN)
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic        is_byte, is_half, is_word;
  logic [31:0] bsh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    is_load  = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_store = op inside {OP_SB, OP_SH, OP_SW};
`ifdef MEM_LSU_LLSC_EN
    is_load  = is_load  || op == OP_LL;
    is_store = is_store || op == OP_SC;
`endif
    is_byte    = op inside {OP_LB, OP_LBU, OP_SB};
    is_half    = op inside {OP_LH, OP_LHU, OP_SH};
    is_word    = (is_load || is_store) && !is_byte && !is_half;
    misaligned = is_half ? addr_lo[0] : is_word ? |addr_lo : 1'b0;
    sel        = is_byte ? 4'b0001 << addr_lo : is_half ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata      = is_byte ? {4{sdata[7:0]}} : is_half ? {2{sdata[15:0]}} : sdata;
    bsh        = rdata >> {addr_lo, 3'b000};
    b          = bsh[7:0];
    h          = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ldata      = op == OP_LB  ? {{24{b[7]}}, b} :
                 op == OP_LBU ? {24'h0, b} :
                 op == OP_LH  ? {{16{h[15]}}, h} :
                 op == OP_LHU ? {16'h0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with load/store unit, bus handshake and timeout
// Optional LL/SC link bit enabled by MEM_LSU_LLSC_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_sdata,
  input  logic              we_i,
  input  logic [REG_AW-1:0] w_addr_i,
  input  logic [31:0]       w_data_i,
  input  logic [31:0]       hi_i,
  input  logic [31:0]       lo_i,
  input  logic              hilo_we_i,
  output logic              out_valid,
  output logic              we_o,
  output logic [REG_AW-1:0] w_addr_o,
  output logic [31:0]       w_data_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  output logic              hilo_we_o,
  output logic [1:0]        exc_o,
  output logic              stall_req,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e            state, state_d;
  logic [3:0]        op_q, cur_op;
  logic [1:0]        alo_q, cur_lo;
  logic              we_q, hwe_q;
  logic [REG_AW-1:0] wa_q;
  logic [31:0]       wd_q, hi_q, lo_q;
  logic [7:0]        cnt;
  logic              is_load, is_store, misaligned;
  logic [3:0]        sel;
  logic [31:0]       wdata, ldata;
  logic              accept, go_bus, ack_done, tmo, sc_op, sc_fail;
  // While waiting, decode from the captured op/offset so load data extracts correctly
  assign cur_op   = state == IDLE ? mem_op : op_q;
  assign cur_lo   = state == IDLE ? mem_addr[1:0] : alo_q;
  assign in_ready = state == IDLE;
  mem_stage_lsu_align u_align (
    .op(cur_op), .addr_lo(cur_lo), .sdata(mem_sdata), .rdata(bus_rdata),
    .is_load(is_load), .is_store(is_store), .misaligned(misaligned),
    .sel(sel), .wdata(wdata), .ldata(ldata)
  );
`ifdef MEM_LSU_LLSC_EN
  logic llbit;
  assign sc_op   = cur_op == OP_SC;
  assign sc_fail = sc_op && !llbit;
  always_ff @(posedge clk)
    if (rst) llbit <= 1'b0;
    else if (ack_done && cur_op == OP_LL) llbit <= 1'b1;
    else if (sc_op && (ack_done || (accept && !go_bus))) llbit <= 1'b0;
`else
  assign sc_op   = 1'b0;
  assign sc_fail = 1'b0;
`endif
  always_comb begin
    accept   = in_valid && state == IDLE;
    go_bus   = accept && (is_load || is_store) && !misaligned && !sc_fail;
    ack_done = state == WAIT && bus_ack;
    tmo      = state == WAIT && !bus_ack && cnt == 8'(TIMEOUT_CYC - 1);
    state_d  = go_bus ? WAIT : (ack_done || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      we_o      <= WRITE_DIS;
      w_addr_o  <= REG_AW'(NOP_REG);
      w_data_o  <= ZERO_WORD;
      hi_o      <= ZERO_WORD;
      lo_o      <= ZERO_WORD;
      hilo_we_o <= WRITE_DIS;
      exc_o     <= EXC_NONE;
      stall_req <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= 4'h0;
      bus_wdata <= ZERO_WORD;
      cnt       <= 8'd0;
      op_q      <= OP_NONE;
      alo_q     <= 2'd0;
      we_q      <= WRITE_DIS;
      wa_q      <= REG_AW'(NOP_REG);
      wd_q      <= ZERO_WORD;
      hi_q      <= ZERO_WORD;
      lo_q      <= ZERO_WORD;
      hwe_q     <= WRITE_DIS;
    end else begin
      out_valid <= 1'b0;
      cnt       <= (state == WAIT && !ack_done && !tmo) ? cnt + 8'd1 : 8'd0;
      if (go_bus) begin
        bus_req   <= 1'b1;
        stall_req <= 1'b1;
        bus_we    <= is_store;
        bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
        bus_sel   <= sel;
        bus_wdata <= wdata;
        op_q      <= mem_op;
        alo_q     <= mem_addr[1:0];
        we_q      <= we_i;
        wa_q      <= w_addr_i;
        wd_q      <= w_data_i;
        hi_q      <= hi_i;
        lo_q      <= lo_i;
        hwe_q     <= hilo_we_i;
      end else if (accept) begin
        out_valid <= 1'b1;
        w_addr_o  <= w_addr_i;
        hi_o      <= hi_i;
        lo_o      <= lo_i;
        exc_o     <= misaligned ? (is_load ? EXC_LMIS : EXC_SMIS) : EXC_NONE;
        we_o      <= misaligned ? WRITE_DIS : sc_op ? WRITE_EN : we_i;
        w_data_o  <= (sc_op && !misaligned) ? ZERO_WORD : w_data_i;
        hilo_we_o <= misaligned ? WRITE_DIS : hilo_we_i;
      end
      if (ack_done || tmo) begin
        bus_req   <= 1'b0;
        stall_req <= 1'b0;
        out_valid <= 1'b1;
        w_addr_o  <= wa_q;
        hi_o      <= hi_q;
        lo_o      <= lo_q;
        exc_o     <= tmo ? EXC_BUS : EXC_NONE;
        hilo_we_o <= tmo ? WRITE_DIS : hwe_q;
        we_o      <= (tmo || (!is_load && !sc_op)) ? WRITE_DIS : sc_op ? WRITE_EN : we_q;
        w_data_o  <= tmo ? wd_q : sc_op ? 32'd1 : is_load ? ldata : wd_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] mem_addr = 32'h0, mem_sdata = 32'h0;
  logic        we_i = 1'b0, hilo_we_i = 1'b0;
  logic [4:0]  w_addr_i = 5'd0, w_addr_o;
  logic [31:0] w_data_i = 32'h0, hi_i = 32'h0, lo_i = 32'h0;
  logic        out_valid, we_o, hilo_we_o, stall_req, bus_req, bus_we;
  logic [31:0] w_data_o, hi_o, lo_o, bus_addr, bus_wdata;
  logic [1:0]  exc_o;
  logic [3:0]  bus_sel;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  int checks = 0, failures = 0;
  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .we_i(we_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .hi_i(hi_i), .lo_i(lo_i), .hilo_we_i(hilo_we_i),
    .out_valid(out_valid), .we_o(we_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o), .exc_o(exc_o),
    .stall_req(stall_req), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = 1'b1; mem_op = op; mem_addr = addr; mem_sdata = sd;
    we_i = we; w_addr_i = wa; w_data_i = wd;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_w_addr", 32'(w_addr_o), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_exc", 32'(exc_o), 32'd0);
    hi_i = 32'h0000_000A; lo_i = 32'h0000_000B; hilo_we_i = 1'b1;
    issue(4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_w_addr", 32'(w_addr_o), 32'd5);
    check("pt_w_data", w_data_o, 32'h1234);
    check("pt_we", 32'(we_o), 32'd1);
    check("pt_hi", hi_o, 32'hA);
    check("pt_lo", lo_o, 32'hB);
    check("pt_hilo_we", 32'(hilo_we_o), 32'd1);
    check("pt_bus_req", 32'(bus_req), 32'd0);
    tick();
    check("pt_valid_drop", 32'(out_valid), 32'd0);
    hilo_we_i = 1'b0;
    issue(4'd1, 32'h103, 32'h0, 1'b1, 5'd7, 32'h0);
    check("lb_bus_req", 32'(bus_req), 32'd1);
    check("lb_sel", 32'(bus_sel), 32'h8);
    check("lb_addr", bus_addr, 32'h100);
    check("lb_we", 32'(bus_we), 32'd0);
    check("lb_in_ready", 32'(in_ready), 32'd0);
    check("lb_stall1", 32'(stall_req), 32'd1);
    tick();
    check("lb_stall2", 32'(stall_req), 32'd1);
    tick();
    check("lb_stall3", 32'(stall_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h80FF_0011;
    tick();
    bus_ack = 1'b0;
    check("lb_valid", 32'(out_valid), 32'd1);
    check("lb_data", w_data_o, 32'hFFFF_FF80);
    check("lb_we_o", 32'(we_o), 32'd1);
    check("lb_w_addr", 32'(w_addr_o), 32'd7);
    check("lb_stall_drop", 32'(stall_req), 32'd0);
    check("lb_req_drop", 32'(bus_req), 32'd0);
    issue(4'd7, 32'h202, 32'hAAAA_BEEF, 1'b1, 5'd3, 32'h0);
    check("sh_sel", 32'(bus_sel), 32'hC);
    check("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    check("sh_bus_we", 32'(bus_we), 32'd1);
    check("sh_addr", bus_addr, 32'h200);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("sh_valid", 32'(out_valid), 32'd1);
    check("sh_we_o", 32'(we_o), 32'd0);
    check("sh_req_drop", 32'(bus_req), 32'd0);
    issue(4'd4, 32'h302, 32'h0, 1'b1, 5'd9, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h8001_0000;
    tick();
    bus_ack = 1'b0;
    check("lhu_data", w_data_o, 32'h0000_8001);
    hilo_we_i = 1'b1;
    issue(4'd5, 32'h101, 32'h0, 1'b1, 5'd4, 32'h0);
    check("lwmis_req", 32'(bus_req), 32'd0);
    check("lwmis_valid", 32'(out_valid), 32'd1);
    check("lwmis_exc", 32'(exc_o), 32'd1);
    check("lwmis_we", 32'(we_o), 32'd0);
    check("lwmis_hilo_we", 32'(hilo_we_o), 32'd0);
    issue(4'd8, 32'h102, 32'h0, 1'b1, 5'd4, 32'h0);
    check("swmis_exc", 32'(exc_o), 32'd2);
    check("swmis_req", 32'(bus_req), 32'd0);
    hilo_we_i = 1'b0;
    issue(4'd8, 32'h400, 32'h5555_5555, 1'b1, 5'd2, 32'h0);
    check("to_req_start", 32'(bus_req), 32'd1);
    for (int i = 0; i < 14; i++) tick();
    check("to_req_15th", 32'(bus_req), 32'd1);
    check("to_no_valid", 32'(out_valid), 32'd0);
    tick();
    check("to_req_drop", 32'(bus_req), 32'd0);
    check("to_valid", 32'(out_valid), 32'd1);
    check("to_exc", 32'(exc_o), 32'd3);
    check("to_we", 32'(we_o), 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("to_late_ack_valid", 32'(out_valid), 32'd0);
    check("to_late_ack_req", 32'(bus_req), 32'd0);
    check("to_in_ready", 32'(in_ready), 32'd1);
    issue(4'd5, 32'h500, 32'h0, 1'b1, 5'd6, 32'h0);
    check("rw_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_req_drop", 32'(bus_req), 32'd0);
    check("rw_valid", 32'(out_valid), 32'd0);
    check("rw_in_ready", 32'(in_ready), 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("rw_late_ack", 32'(out_valid), 32'd0);
`ifdef MEM_LSU_LLSC_EN
    issue(4'd9, 32'h600, 32'h0, 1'b1, 5'd8, 32'h0);
    check("ll_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    check("ll_data", w_data_o, 32'h1234_5678);
    issue(4'd10, 32'h600, 32'hCAFE_F00D, 1'b1, 5'd8, 32'h0);
    check("sc1_req", 32'(bus_req), 32'd1);
    check("sc1_bus_we", 32'(bus_we), 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("sc1_data", w_data_o, 32'd1);
    check("sc1_we", 32'(we_o), 32'd1);
    issue(4'd10, 32'h600, 32'hCAFE_F00D, 1'b1, 5'd8, 32'h77);
    check("sc2_req", 32'(bus_req), 32'd0);
    check("sc2_valid", 32'(out_valid), 32'd1);
    check("sc2_data", w_data_o, 32'd0);
    check("sc2_we", 32'(we_o), 32'd1);
`else
    issue(4'd10, 32'h600, 32'h0, 1'b1, 5'd8, 32'h77);
    check("sc_none_req", 32'(bus_req), 32'd0);
    check("sc_none_valid", 32'(out_valid), 32'd1);
    check("sc_none_data", w_data_o, 32'h77);
    check("sc_none_exc", 32'(exc_o), 32'd0);
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
